// File: rtl/genius_pkg.sv
// Shared types and defaults for the Genius sequence player.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package genius_pkg;

    localparam int COLOR_CODEFY_W = 2;
    localparam int ADDR_WIDTH     = 5;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        RED    = 2'b01,
        BLUE   = 2'b10,
        YELLOW = 2'b11
    } color_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        LED_ON,
        LED_OFF,
        FINISH
    } player_state_e;

    // Largest of four durations; sizes the shared on/off down-counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/led_decoder.sv
// Maps a color code plus enable onto four one-hot LED lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module led_decoder
    import genius_pkg::*;
(
    input  color_e color_i,
    input  logic   en_i,
    output logic   led_green_o,
    output logic   led_red_o,
    output logic   led_blue_o,
    output logic   led_yellow_o
);

    // One LED per code while enabled, all dark otherwise.
    always_comb begin
        led_green_o  = 1'b0;
        led_red_o    = 1'b0;
        led_blue_o   = 1'b0;
        led_yellow_o = 1'b0;
        if (en_i) begin
            case (color_i)
                GREEN:   led_green_o  = 1'b1;
                RED:     led_red_o    = 1'b1;
                BLUE:    led_blue_o   = 1'b1;
                YELLOW:  led_yellow_o = 1'b1;
                default: led_green_o  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/seq_player.sv
// Plays a stored color sequence on four LEDs with fixed on/off timing.
// Latency: start -> read strobe 1 cycle, LED on from cycle 3; 2+ON+OFF cycles per color.
// Backpressure: none; start requests while busy are dropped, abort always wins.
module seq_player
    import genius_pkg::*;
#(
    parameter int COLOR_CODEFY_W = genius_pkg::COLOR_CODEFY_W,
    parameter int ADDR_WIDTH     = genius_pkg::ADDR_WIDTH,
    parameter int FAST_ON        = 4,
    parameter int FAST_OFF       = 2,
    parameter int SLOW_ON        = 8,
    parameter int SLOW_OFF       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      play_start,
    input  logic                      abort,
    input  logic                      speed,
    input  logic [ADDR_WIDTH-1:0]     seq_len,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [COLOR_CODEFY_W-1:0] mem_rdata,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_DUR = max4(FAST_ON, FAST_OFF, SLOW_ON, SLOW_OFF);
    localparam int TW      = $clog2(MAX_DUR + 1);

    localparam logic [TW-1:0] T_FAST_ON  = TW'(FAST_ON);
    localparam logic [TW-1:0] T_FAST_OFF = TW'(FAST_OFF);
    localparam logic [TW-1:0] T_SLOW_ON  = TW'(SLOW_ON);
    localparam logic [TW-1:0] T_SLOW_OFF = TW'(SLOW_OFF);
    localparam logic [TW-1:0] T_ONE      = TW'(1);

    player_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]      index_q, index_d;
    logic [ADDR_WIDTH-1:0]      len_q, len_d;
    logic                       speed_q, speed_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [COLOR_CODEFY_W-1:0]  color_q, color_d;

    logic                       rd_en_c;
    logic                       led_en_c;
    logic                       done_c;
    logic [ADDR_WIDTH:0]        idx_inc;

    // One extra bit so the last-color test cannot alias when len is at its maximum.
    assign idx_inc = {1'b0, index_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // State and datapath registers; reset discards any playback in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            len_q   <= '0;
            speed_q <= 1'b0;
            timer_q <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            len_q   <= len_d;
            speed_q <= speed_d;
            timer_q <= timer_d;
            color_q <= color_d;
        end
    end

    // Next-state and strobe logic; length and speed are only sampled in IDLE.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        len_d    = len_q;
        speed_d  = speed_q;
        timer_d  = timer_q;
        color_d  = color_q;
        rd_en_c  = 1'b0;
        led_en_c = 1'b0;
        done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (play_start && !abort) begin
                    len_d   = seq_len;
                    speed_d = speed;
                    index_d = '0;
                    state_d = FETCH;
                end
            end
            // The empty-sequence check uses the latched length, so a zero-length
            // request spends one silent cycle here before finishing.
            FETCH: begin
                if (len_q == '0) begin
                    state_d = FINISH;
                end else begin
                    rd_en_c = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                color_d = mem_rdata;
                timer_d = speed_q ? T_FAST_ON : T_SLOW_ON;
                state_d = LED_ON;
            end
            LED_ON: begin
                led_en_c = 1'b1;
                if (timer_q <= T_ONE) begin
                    timer_d = speed_q ? T_FAST_OFF : T_SLOW_OFF;
                    state_d = LED_OFF;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            LED_OFF: begin
                if (timer_q <= T_ONE) begin
                    timer_d = '0;
                    index_d = idx_inc[ADDR_WIDTH-1:0];
                    state_d = (idx_inc == {1'b0, len_q}) ? FINISH : FETCH;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            FINISH: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort silences everything this cycle and returns to IDLE next cycle.
        if (abort) begin
            state_d  = IDLE;
            timer_d  = '0;
            rd_en_c  = 1'b0;
            led_en_c = 1'b0;
            done_c   = 1'b0;
        end
    end

    assign mem_rd_en = rd_en_c;
    assign mem_addr  = index_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_c;

    led_decoder u_led_decoder (
        .color_i      (color_e'(color_q[1:0])),
        .en_i         (led_en_c),
        .led_green_o  (led_green),
        .led_red_o    (led_red),
        .led_blue_o   (led_blue),
        .led_yellow_o (led_yellow)
    );

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: per-cycle expected output traces are queued at start.
// Latency: checks every cycle from the one after play_start.
// Backpressure: n/a.
module tb_seq_player;
    import genius_pkg::*;

    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          play_start;
    logic          abort;
    logic          speed;
    logic [AW-1:0] seq_len;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_rdata;
    logic          led_green, led_red, led_blue, led_yellow;
    logic          busy, done;

    seq_player #(
        .COLOR_CODEFY_W (2),
        .ADDR_WIDTH     (AW),
        .FAST_ON        (4),
        .FAST_OFF       (2),
        .SLOW_ON        (8),
        .SLOW_OFF       (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_start (play_start),
        .abort      (abort),
        .speed      (speed),
        .seq_len    (seq_len),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .led_green  (led_green),
        .led_red    (led_red),
        .led_blue   (led_blue),
        .led_yellow (led_yellow),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence memory model: registered read, data one cycle after the strobe.
    logic [1:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // {busy, done, rd_en, addr (only while rd_en), yellow, blue, red, green}
    typedef struct packed {
        logic        chk;
        logic [11:0] v;
    } rec_t;

    rec_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    string test_name = "init";

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s got=%h exp=%h at %0t", test_name, tag, got, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic b, input logic d, input logic rd,
                                input logic [4:0] a, input logic [3:0] leds);
        rec_t r;
        r.chk = 1'b1;
        r.v   = {b, d, rd, (rd ? a : 5'd0), leds};
        return r;
    endfunction

    function automatic logic [11:0] observed();
        return {busy, done, mem_rd_en, (mem_rd_en ? mem_addr : 5'd0),
                led_yellow, led_blue, led_red, led_green};
    endfunction

    // Scoreboard consumer: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        rec_t r;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            if (r.chk) check_vec("cycle", 32'(observed()), 32'(r.v));
        end
    end

    // Expected trace of a playback that started the previous cycle; cut>0 marks the
    // cycle (1-based) where it is interrupted: that cycle is unchecked, then idle.
    task automatic gen(input bit spd, input int len, input int cut);
        rec_t t[$];
        rec_t dc;
        int on_c  = spd ? 4 : 8;
        int off_c = spd ? 2 : 4;
        logic [3:0] oh;
        if (len == 0) begin
            t.push_back(mk(1, 0, 0, 0, 0));
        end else begin
            for (int i = 0; i < len; i++) begin
                oh = 4'b0001 << mem[i];
                t.push_back(mk(1, 0, 1, 5'(i), 0));
                t.push_back(mk(1, 0, 0, 0, 0));
                for (int k = 0; k < on_c; k++)  t.push_back(mk(1, 0, 0, 0, oh));
                for (int k = 0; k < off_c; k++) t.push_back(mk(1, 0, 0, 0, 0));
            end
        end
        t.push_back(mk(1, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) t.push_back(mk(0, 0, 0, 0, 0));
        dc = mk(0, 0, 0, 0, 0);
        dc.chk = 1'b0;
        for (int c = 0; c < t.size(); c++) begin
            if (cut != 0 && c + 1 == cut) begin
                exp_q.push_back(dc);
                for (int k = 0; k < 10; k++) exp_q.push_back(mk(0, 0, 0, 0, 0));
                break;
            end
            exp_q.push_back(t[c]);
        end
    endtask

    task automatic start_play(input bit spd, input int len, input int cut);
        @(posedge clk); #1;
        speed      = spd;
        seq_len    = AW'(len);
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        gen(spd, len, cut);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            check_vec("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        play_start = 1'b0;
        abort      = 1'b0;
        speed      = 1'b0;
        seq_len    = '0;
        mem_rdata  = '0;
        for (int i = 0; i < 32; i++) mem[i] = 2'(i);

        test_name = "reset";
        #12;
        check_vec("outs", 32'(observed()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        test_name = "fast3";
        mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
        start_play(1, 3, 0);
        wait_drain();

        test_name = "slow1";
        mem[0] = 2'd3;
        start_play(0, 1, 0);
        wait_drain();

        test_name = "len0";
        start_play(1, 0, 0);
        wait_drain();

        test_name = "abort";
        mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd2;
        start_play(1, 3, 12);
        repeat (11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_drain();

        test_name = "ignore";
        mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;
        start_play(1, 3, 0);
        repeat (3) @(posedge clk);
        #1 play_start = 1'b1; speed = 1'b0; seq_len = 5'd9;
        @(posedge clk);
        #1 play_start = 1'b0;
        repeat (6) @(posedge clk);
        #1 play_start = 1'b1; speed = 1'b1; seq_len = 5'd1;
        @(posedge clk);
        #1 play_start = 1'b0; speed = 1'b0;
        wait_drain();

        test_name = "start_abort";
        @(posedge clk);
        #1 play_start = 1'b1; abort = 1'b1; seq_len = 5'd2;
        @(posedge clk);
        #1 play_start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 0, 0));
        wait_drain();

        test_name = "rst_mid";
        mem[0] = 2'd3; mem[1] = 2'd0;
        start_play(1, 2, 7);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check_vec("async_outs", 32'(observed()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_drain();
        test_name = "rst_replay";
        start_play(1, 2, 0);
        wait_drain();

        test_name = "maxlen";
        for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(0, 3));
        start_play(1, 31, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
